counter_mod_k_measure: RTL and testbench
========================================

# counter_mod_k_measure

Period meter that recovers the modulus k from a strobe stream, such as the wrap pulse of a mod-k counter. It counts clock cycles between consecutive strobes and publishes the measured period with valid and overflow flags. It sits on the observing side of the mod-k counter, in checkers and clock-ratio monitors that read back k instead of driving it.

## Interface
- `N`, default 8: width of the period counter and of `o_k`. Measurable periods are 1 to 2^N-1.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_clear` in 1: synchronous clear; returns the block to IDLE and clears all outputs.
- `i_strobe` in 1: event input. Every cycle where it is high counts as one event; no edge detection.
- `o_k` out N: last published period, in clock cycles.
- `o_valid` out 1: `o_k` holds a valid measurement.
- `o_update` out 1: one-cycle pulse each time `o_k` is written.
- `o_overflow` out 1: no strobe arrived within 2^N-1 cycles.

## Operation
- The state machine has three states: IDLE, RUN and OVF.
- Internal counter `m_cnt` is N bits.
- **IDLE**
  - Waits for the first strobe.
  - On strobe: `m_cnt`<=1, go to RUN. No output change.
- **RUN, strobe high**
  - Measurement p=`m_cnt` is complete. Publish p as described under Configuration.
  - Then `m_cnt`<=1 and stay in RUN.
  - Strobes at cycles t and t+p yield p. A strobe every cycle yields 1.
- **RUN, strobe low, `m_cnt`<2^N-1**: `m_cnt`<=`m_cnt`+1.
- **RUN, strobe low, `m_cnt`=2^N-1**
  - Go to OVF.
  - `o_overflow`<=1, `o_valid`<=0.
  - `o_k` holds its stale value.
  - Discard any pending stable-mode candidate.
- **OVF**
  - `m_cnt` is frozen.
  - On strobe: `m_cnt`<=1, go to RUN; this strobe only starts a new measurement.
  - `o_overflow` stays 1 until the next publish.
- A publish always sets `o_overflow`<=0.
- `i_clear` takes priority over everything else:
  - state<=IDLE, `m_cnt`<=0, all outputs <=0, candidate discarded.
  - A strobe in the same cycle is ignored, so the next strobe counts as the first.
- Arithmetic is unsigned N-bit. `m_cnt` never wraps; it saturates into OVF.

## Timing
- **Reset values**: `o_k`=0, `o_valid`=0, `o_update`=0, `o_overflow`=0; state IDLE, `m_cnt`=0, candidate empty.
- Reset assertion takes effect immediately, without waiting for a clock edge.
- All outputs are registered.
- **Publish latency**: a strobe sampled at edge e becomes visible on `o_k`, `o_valid` and `o_update` just after e, i.e. during cycle e+1.
- `o_update` is high for exactly one cycle per publish. Back-to-back strobes give back-to-back pulses.
- **Overflow timing**: after a strobe at t, with no further strobe, `o_overflow` rises in cycle t+2^N. A strobe at exactly t+2^N-1 still publishes 2^N-1.
- **Reset mid-measurement**: the partial count is lost and the next strobe after reset is treated as the first.

## Configuration
- `COUNTER_MOD_K_MEASURE_STABLE_EN` selects the publish rule.
- **Without the macro**, every completed measurement p publishes immediately: `o_k`<=p, `o_valid`<=1, `o_update` pulse.
- **With the macro**, a measurement publishes only when it equals the previous one:
  - The block keeps a candidate register `m_last` and a flag `m_have_last`.
  - If p equals `m_last` and `m_have_last` is set: publish p (`o_k`<=p, `o_valid`<=1, `o_update` pulse).
  - Otherwise: `o_valid`<=0, `m_last`<=p, `m_have_last`<=1; `o_k` holds its stale value and there is no `o_update`.
  - Consequence: the first valid output needs three strobes, and any period change drops `o_valid` for one measurement.

## Test plan
1. Strobe every 5 cycles, macro off:
   - After the 2nd strobe, `o_k`=5, `o_valid`=1, `o_update` pulses.
   - From then on, one `o_update` per strobe.
   - Macro on: the first valid output follows the 3rd strobe.
2. Strobe held high continuously:
   - From the 2nd strobe on, `o_k`=1 and `o_update` is high every cycle (macro off).
   - Macro on: `o_k`=1 and `o_valid`=1 from the 3rd strobe on.
3. N=4, strobes 20 cycles apart:
   - `o_overflow`=1 and `o_valid`=0 from cycle t+16.
   - Then strobes 7 apart: `o_k`=7, `o_overflow`=0.
4. N=4, strobes exactly 15 apart: `o_k`=15 and `o_overflow` never set.
5. `i_clear` high in the same cycle as a strobe:
   - All outputs 0, no update.
   - Two further strobes 3 cycles apart give `o_k`=3.
6. Macro on, period changes 5 to 6: `o_valid` drops after the first 6-measurement and returns with `o_k`=6 after the second. Separately, `i_reset_n` pulsed low mid-run forces all outputs to 0 without a clock edge.

Source files
------------

// File: rtl/counter_mod_k_measure.sv
// counter_mod_k_measure: period meter that recovers the modulus k of a strobe
// stream by counting clock cycles between consecutive strobes.
// Optional build macro: COUNTER_MOD_K_MEASURE_STABLE_EN. When it is defined,
// a period is published only after two consecutive equal measurements.
// Without the macro, every completed measurement is published immediately.
module counter_mod_k_measure #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic         i_strobe,
  output logic [N-1:0] o_k,
  output logic         o_valid,
  output logic         o_update,
  output logic         o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OVF
  } state_e;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_e       state_q;
  logic [N-1:0] cnt_q;

`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
  logic [N-1:0] last_q;
  logic         have_last_q;
`endif

  // Measurement FSM with registered outputs; clear overrides everything else.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      o_k         <= '0;
      o_valid     <= 1'b0;
      o_update    <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
      last_q      <= '0;
      have_last_q <= 1'b0;
`endif
    end else begin
      o_update <= 1'b0;
      if (i_clear) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        o_k         <= '0;
        o_valid     <= 1'b0;
        o_overflow  <= 1'b0;
`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
        last_q      <= '0;
        have_last_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            // First strobe only starts timing; outputs are untouched.
            if (i_strobe) begin
              cnt_q   <= CNT_ONE;
              state_q <= S_RUN;
            end
          end

          S_RUN: begin
            if (i_strobe) begin
              // cnt_q holds the completed period at this edge.
`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
              if (have_last_q && (cnt_q == last_q)) begin
                o_k        <= cnt_q;
                o_valid    <= 1'b1;
                o_update   <= 1'b1;
                o_overflow <= 1'b0;
              end else begin
                o_valid     <= 1'b0;
                last_q      <= cnt_q;
                have_last_q <= 1'b1;
              end
`else
              o_k        <= cnt_q;
              o_valid    <= 1'b1;
              o_update   <= 1'b1;
              o_overflow <= 1'b0;
`endif
              cnt_q <= CNT_ONE;
            end else if (cnt_q == CNT_MAX) begin
              // Saturate instead of wrapping; o_k keeps its stale value.
              state_q    <= S_OVF;
              o_overflow <= 1'b1;
              o_valid    <= 1'b0;
`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
              have_last_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          S_OVF: begin
            // Counter frozen; the next strobe only opens a new measurement.
            if (i_strobe) begin
              cnt_q   <= CNT_ONE;
              state_q <= S_RUN;
            end
          end

          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_mod_k_measure.sv
// tb_counter_mod_k_measure: directed and randomized checks of the period meter
// against a timestamp-based reference model. Honours the same optional macro
// COUNTER_MOD_K_MEASURE_STABLE_EN as the design.
module tb_counter_mod_k_measure;

  localparam int N    = 4;
  localparam int MAXP = (1 << N) - 1;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         strobe;
  logic [N-1:0] o_k;
  logic         o_valid;
  logic         o_update;
  logic         o_overflow;

  int tests;
  int fails;

  // Reference model state: timestamps rather than a cycle counter.
  int           cyc;
  bit           armed;
  int           start_cyc;
  logic [N-1:0] exp_k;
  logic         exp_valid;
  logic         exp_update;
  logic         exp_ovf;
  bit           cand_have;
  int           cand_p;

  counter_mod_k_measure #(.N(N)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_clear    (clr),
    .i_strobe   (strobe),
    .o_k        (o_k),
    .o_valid    (o_valid),
    .o_update   (o_update),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    armed      = 1'b0;
    start_cyc  = 0;
    exp_k      = '0;
    exp_valid  = 1'b0;
    exp_update = 1'b0;
    exp_ovf    = 1'b0;
    cand_have  = 1'b0;
    cand_p     = 0;
  endtask

  task automatic model_publish(input int p);
`ifdef COUNTER_MOD_K_MEASURE_STABLE_EN
    if (cand_have && p == cand_p) begin
      exp_k      = p[N-1:0];
      exp_valid  = 1'b1;
      exp_update = 1'b1;
      exp_ovf    = 1'b0;
    end else begin
      exp_valid = 1'b0;
      cand_p    = p;
      cand_have = 1'b1;
    end
`else
    exp_k      = p[N-1:0];
    exp_valid  = 1'b1;
    exp_update = 1'b1;
    exp_ovf    = 1'b0;
`endif
  endtask

  task automatic model_edge(input bit s, input bit c);
    int p;
    cyc++;
    exp_update = 1'b0;
    if (c) begin
      model_reset();
    end else if (!armed) begin
      if (s) begin
        armed     = 1'b1;
        start_cyc = cyc;
      end
    end else begin
      p = cyc - start_cyc;
      if (s) begin
        model_publish(p);
        start_cyc = cyc;
      end else if (p >= MAXP) begin
        exp_ovf   = 1'b1;
        exp_valid = 1'b0;
        cand_have = 1'b0;
        armed     = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    tests++;
    assert (o_k === exp_k) else begin
      fails++;
      $error("FAIL %s o_k got %0d want %0d", tag, o_k, exp_k);
    end
    tests++;
    assert (o_valid === exp_valid) else begin
      fails++;
      $error("FAIL %s o_valid got %b want %b", tag, o_valid, exp_valid);
    end
    tests++;
    assert (o_update === exp_update) else begin
      fails++;
      $error("FAIL %s o_update got %b want %b", tag, o_update, exp_update);
    end
    tests++;
    assert (o_overflow === exp_ovf) else begin
      fails++;
      $error("FAIL %s o_overflow got %b want %b", tag, o_overflow, exp_ovf);
    end
  endtask

  task automatic step(input bit s, input bit c, input string tag);
    @(negedge clk);
    strobe = s;
    clr    = c;
    @(posedge clk);
    model_edge(s, c);
    #1;
    check_outputs(tag);
  endtask

  // count strobes spaced p cycles apart (the trailing gap follows each strobe)
  task automatic strobes_every(input int p, input int count, input string tag);
    for (int i = 0; i < count; i++) begin
      step(1'b1, 1'b0, tag);
      for (int j = 0; j < p - 1; j++) step(1'b0, 1'b0, tag);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    @(negedge clk);
    strobe = 1'b0;
    clr    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    strobe = 1'b0;
    model_reset();
    #23;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Period 5, then continuous strobe.
    strobes_every(5, 5, "period5");
    strobes_every(1, 6, "cont");
    idle_cycles(3, "gap");

    // Overflow with strobes 20 apart, then recovery with period 7.
    strobes_every(20, 3, "ovf20");
    strobes_every(7, 4, "period7");

    // Boundary: exactly 2^N-1 apart never overflows.
    strobes_every(MAXP, 4, "period15");
    strobes_every(MAXP + 1, 2, "period16");
    strobes_every(3, 3, "period3");

    // Clear coincident with a strobe, then two strobes 3 apart.
    step(1'b1, 1'b1, "clr_strobe");
    idle_cycles(2, "after_clr");
    strobes_every(3, 3, "clr_then3");

    // Period change 5 -> 6.
    strobes_every(5, 4, "chg5");
    strobes_every(6, 4, "chg6");

    // Asynchronous reset mid-measurement.
    idle_cycles(2, "pre_rst");
    async_reset_pulse("async_rst");
    idle_cycles(2, "post_rst");
    strobes_every(4, 3, "after_rst");

    // Randomized bursts of repeated periods with occasional clears.
    for (int b = 0; b < 120; b++) begin
      int p;
      int reps;
      p    = $urandom_range(1, MAXP + 3);
      reps = $urandom_range(1, 4);
      for (int r = 0; r < reps; r++) begin
        step(1'b1, ($urandom_range(0, 49) == 0), "rand");
        for (int j = 0; j < p - 1; j++)
          step(1'b0, ($urandom_range(0, 199) == 0), "rand");
      end
      if ($urandom_range(0, 29) == 0) async_reset_pulse("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
